// File: rtl/indicators_pkg.sv
// Shared constants and elaboration-time helpers for the LED indicator blocks.
package indicators_pkg;

  // PWM tick rate and the number of ticks in one millisecond.
  localparam int TICK_HZ      = 32'sd2000000;
  localparam int TICKS_PER_MS = 32'sd2000;

  // Integer divide that never yields less than 1, so derived counts stay usable.
  function automatic int safe_div(input int num, input int den);
    int q;
    if (den <= 32'sd0) begin
      q = 32'sd1;
    end else begin
      q = num / den;
    end
    return (q < 32'sd1) ? 32'sd1 : q;
  endfunction

  // Number of bits needed to hold the values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 32'sd1;
      end
    end
    return r;
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
  endfunction

endpackage

// File: rtl/event_sync.sv
// Brings one asynchronous event input into the clk domain and turns each
// rising edge into a single-cycle pulse (two-flop synchroniser + edge register).
module event_sync (
  input  logic clk,
  input  logic reset,
  input  logic event_in,
  output logic evt_edge
);

  logic meta_r;
  logic sync_r;
  logic sync_d_r;
  logic edge_r;

  // Synchroniser chain and registered rising-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      sync_d_r <= 1'b0;
      edge_r   <= 1'b0;
    end else begin
      meta_r   <= event_in;
      sync_r   <= meta_r;
      sync_d_r <= sync_r;
      edge_r   <= sync_r & ~sync_d_r;
    end
  end

  assign evt_edge = edge_r;

endmodule

// File: rtl/activity_indicators.sv
// Event-driven LED activity indicators: each channel jumps to full brightness
// on an input rising edge, then fades linearly to dark; outputs are PWM drives.
module activity_indicators
  import indicators_pkg::*;
#(
  parameter int CLK_FREQUENCY = 14000000,
  parameter int CHANNELS      = 8,
  parameter int RESOLUTION    = 8,
  parameter int DECAY_MS      = 250
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] event_in,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                active
);

  localparam int MAX_VALUE  = (32'sd1 <<< RESOLUTION) - 32'sd1;
  localparam int DIVIDER    = safe_div(CLK_FREQUENCY, TICK_HZ);
  localparam int DECAY_STEP = safe_div(DECAY_MS * TICKS_PER_MS, MAX_VALUE);
  localparam int PRE_W      = cnt_width(DIVIDER);
  localparam int DEC_W      = cnt_width(DECAY_STEP);

  localparam logic [RESOLUTION-1:0] MAX_LVL  = RESOLUTION'(MAX_VALUE);
  localparam logic [RESOLUTION-1:0] ZERO_LVL = {RESOLUTION{1'b0}};
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(DIVIDER - 32'sd1);
  localparam logic [DEC_W-1:0]      DEC_LAST = DEC_W'(DECAY_STEP - 32'sd1);

  logic [PRE_W-1:0]               pre_cnt_r;
  logic [RESOLUTION-1:0]          pwm_cnt_r;
  logic [DEC_W-1:0]               dec_cnt_r;
  logic                           pwm_tick_s;
  logic                           decay_tick_s;
  logic [CHANNELS-1:0]            evt_edge_s;
  logic [CHANNELS-1:0]            pwm_nxt_s;
  logic [CHANNELS*RESOLUTION-1:0] levels_s;
  logic [CHANNELS-1:0]            pwm_out_r;
  logic                           active_r;

  // Ticks are decoded straight from the counters so they line up with the wrap.
  assign pwm_tick_s   = (pre_cnt_r == PRE_LAST);
  assign decay_tick_s = pwm_tick_s & (dec_cnt_r == DEC_LAST);

  // Prescaler: free-running, independent of enable, sets the PWM tick rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else if (pre_cnt_r == PRE_LAST) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_W'(1'b1);
    end
  end

  // PWM ramp shared by all channels; wraps naturally from MAX to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= ZERO_LVL;
    end else if (pwm_tick_s) begin
      pwm_cnt_r <= pwm_cnt_r + RESOLUTION'(1'b1);
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Global decay timer: one decay step every DECAY_STEP PWM ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt_r <= {DEC_W{1'b0}};
    end else if (pwm_tick_s) begin
      if (dec_cnt_r == DEC_LAST) begin
        dec_cnt_r <= {DEC_W{1'b0}};
      end else begin
        dec_cnt_r <= dec_cnt_r + DEC_W'(1'b1);
      end
    end else begin
      dec_cnt_r <= dec_cnt_r;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [RESOLUTION-1:0] level_r;

    event_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .event_in (event_in[i]),
      .evt_edge (evt_edge_s[i])
    );

    // Brightness level: enable clears, an event wins over a coincident decay,
    // and the decrement stops at zero instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        level_r <= ZERO_LVL;
      end else if (!enable) begin
        level_r <= ZERO_LVL;
      end else if (evt_edge_s[i]) begin
        level_r <= MAX_LVL;
      end else if (decay_tick_s && (level_r != ZERO_LVL)) begin
        level_r <= level_r - RESOLUTION'(1'b1);
      end else begin
        level_r <= level_r;
      end
    end

    // Full level is forced solid on; otherwise a plain level-vs-ramp compare.
    assign pwm_nxt_s[i] = enable & ((level_r == MAX_LVL) | (level_r > pwm_cnt_r));
    assign levels_s[i*RESOLUTION +: RESOLUTION] = level_r;
  end

  // Registered LED drives and the any-channel-lit flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out_r <= {CHANNELS{1'b0}};
      active_r  <= 1'b0;
    end else begin
      pwm_out_r <= pwm_nxt_s;
      active_r  <= |levels_s;
    end
  end

  assign pwm_out = pwm_out_r;
  assign active  = active_r;

endmodule
